// File: rtl/loop_seq_pkg.sv
// Shared types for the loop sequencer: FSM state encoding and its width.
package loop_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/loop_seq_idx.sv
// One wrapping index register: counts 0..MAX on en, wraps to 0 after MAX.
// clear has priority over en.
module loop_seq_idx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX        = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] idx,
  output logic                  at_max
);

  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);

  assign at_max = (idx == MAX_V);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (en) begin
      idx <= at_max ? '0 : idx + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Two-level (row, col) index walker with ready/valid handout and a done pulse.
// Optional registered last flag on the final pair when LOOPSEQ_LAST_EN is defined.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROWMAX     = 27,
  parameter int unsigned COLMAX     = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] row,
  output logic [DATA_WIDTH-1:0] col,
  output logic                  busy,
  output logic                  done
`ifdef LOOPSEQ_LAST_EN
  ,
  output logic                  last
`endif
);

  state_e state_q, state_d;
  logic   hs;
  logic   col_en, row_en, idx_clear;
  logic   col_at_max, row_at_max;

  // valid is a registered copy of (state == RUN), so this is the handshake
  assign hs        = valid & ready;
  assign idx_clear = abort;
  assign col_en    = hs & ~abort;
  assign row_en    = hs & ~abort & col_at_max;

  loop_seq_idx #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX        (COLMAX)
  ) u_col (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (idx_clear),
    .en     (col_en),
    .idx    (col),
    .at_max (col_at_max)
  );

  loop_seq_idx #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX        (ROWMAX)
  ) u_row (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (idx_clear),
    .en     (row_en),
    .idx    (row),
    .at_max (row_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (hs && col_at_max && row_at_max) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Status outputs are registered from the next state so they line up with the indices
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      valid <= (state_d == RUN);
      busy  <= (state_d == RUN) || (state_d == DONE);
      done  <= (state_d == DONE);
    end
  end

`ifdef LOOPSEQ_LAST_EN
  localparam logic [DATA_WIDTH-1:0] ROWMAX_V = DATA_WIDTH'(ROWMAX);
  localparam logic [DATA_WIDTH-1:0] COLMAX_V = DATA_WIDTH'(COLMAX);

  logic [DATA_WIDTH-1:0] row_nxt, col_nxt;

  // Predict the index values the counters will load on this edge
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (idx_clear) begin
      row_nxt = '0;
      col_nxt = '0;
    end else begin
      if (col_en) col_nxt = col_at_max ? '0 : col + DATA_WIDTH'(1);
      if (row_en) row_nxt = row_at_max ? '0 : row + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b0;
    end else begin
      last <= (state_d == RUN) && (row_nxt == ROWMAX_V) && (col_nxt == COLMAX_V);
    end
  end
`endif

endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer (ROWMAX=1, COLMAX=2) plus a 1x1 instance.
// Handles LOOPSEQ_LAST_EN builds as well as the default build.
module tb_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, ready;
  logic        valid, busy, done;
  logic [31:0] row, col;
  logic        z_start, z_abort, z_ready;
  logic        z_valid, z_busy, z_done;
  logic [31:0] z_row, z_col;
`ifdef LOOPSEQ_LAST_EN
  logic        last, z_last;
`endif

  always #5 clk = ~clk;

  loop_sequencer #(.DATA_WIDTH(32), .ROWMAX(1), .COLMAX(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
    .valid(valid), .row(row), .col(col), .busy(busy), .done(done)
`ifdef LOOPSEQ_LAST_EN
    , .last(last)
`endif
  );

  loop_sequencer #(.DATA_WIDTH(32), .ROWMAX(0), .COLMAX(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort), .ready(z_ready),
    .valid(z_valid), .row(z_row), .col(z_col), .busy(z_busy), .done(z_done)
`ifdef LOOPSEQ_LAST_EN
    , .last(z_last)
`endif
  );

  typedef struct {
    int r;
    int c;
    bit fin;
  } pair_t;

  pair_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          fin_prev = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_r, held_c;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    for (int r = 0; r <= 1; r++)
      for (int c = 0; c <= 2; c++) begin
        pair_t p;
        p.r = r; p.c = c; p.fin = (r == 1 && c == 2);
        exp_q.push_back(p);
      end
  endtask

  task automatic push_pair(input int r, input int c);
    pair_t p;
    p.r = r; p.c = c; p.fin = 1'b0;
    exp_q.push_back(p);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && !valid && !done && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_idle_timeout"}, ok, 1);
  endtask

  task automatic wait_pair(input string name, input int r, input int c);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid && row == 32'(r) && col == 32'(c)) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_reach_timeout"}, ok, 1);
  endtask

  // Monitor: pops expected pairs on handshakes, checks holds and done timing
  always @(negedge clk) begin
    bit    hs;
    pair_t p;
    hs = rst_n && !abort && valid && ready;
    p.fin = 1'b0;
    if (held) begin
      check("hold_valid", valid, 1);
      check("hold_row", row, held_r);
      check("hold_col", col, held_c);
    end
    held   = rst_n && !abort && valid && !ready;
    held_r = row;
    held_c = col;
    if (rst_n && (fin_prev || done)) check("done_pulse", done, fin_prev);
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 1, 0);
      end else begin
        p = exp_q.pop_front();
        check("row", row, p.r);
        check("col", col, p.c);
`ifdef LOOPSEQ_LAST_EN
        check("last", last, p.fin);
`endif
      end
    end
    fin_prev = hs && p.fin;
  end

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    z_start = 1'b0; z_abort = 1'b0; z_ready = 1'b0;
    tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    rst_n = 1'b1;
    tick();

    // Pass 1: ready high, six pairs back to back, latency to done
    push_pass();
    ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    check("start_to_done_latency", cyc, 7);
    tick();
    check("post_done_busy", busy, 0);
    check("post_done_done", done, 0);
    wait_idle("pass1");

    // Pass 2: ready toggling 1,0,1,0
    push_pass();
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ready = (i % 2 == 0);
      tick();
      if (!busy && exp_q.size() == 0) break;
    end
    ready = 1'b1;
    wait_idle("pass2");

    // Abort at pair (1,0): no done, indices cleared, fresh start from origin
    push_pair(0, 0); push_pair(0, 1); push_pair(0, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pair("abort", 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_row", row, 0);
    check("abort_col", col, 0);
    tick(); tick();
    check("abort_no_done", done, 0);
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_valid", valid, 1);
    check("restart_row", row, 0);
    check("restart_col", col, 0);
    wait_idle("post_abort");

    // start held high: second pass begins two cycles after done is seen
    push_pass(); push_pass();
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    check("held_start_first_done", done, 1);
    tick();
    check("held_start_idle_gap", valid, 0);
    tick();
    check("held_start_restart_valid", valid, 1);
    check("held_start_restart_row", row, 0);
    check("held_start_restart_col", col, 0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    start = 1'b0;
    wait_idle("held_start");

    // Reset mid-pass at pair (0,2)
    push_pair(0, 0); push_pair(0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pair("reset", 0, 2);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_row", row, 0);
    check("midrst_col", col, 0);
`ifdef LOOPSEQ_LAST_EN
    check("midrst_last", last, 0);
`endif
    rst_n = 1'b1;
    tick();
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("post_reset");

    // Degenerate 1x1 space: single pair then done
    z_ready = 1'b1; z_start = 1'b1;
    tick();
    z_start = 1'b0;
    check("z_valid", z_valid, 1);
    check("z_row", z_row, 0);
    check("z_col", z_col, 0);
    check("z_busy", z_busy, 1);
`ifdef LOOPSEQ_LAST_EN
    check("z_last", z_last, 1);
`endif
    tick();
    check("z_done", z_done, 1);
    check("z_valid_after", z_valid, 0);
    check("z_busy_done", z_busy, 1);
    tick();
    check("z_done_clear", z_done, 0);
    check("z_busy_clear", z_busy, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
